// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, access encodings,
// FSM states and trap constants.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } csr_state_t;

  localparam logic [31:0] ILLEGAL_INS = 32'd2;

  localparam int unsigned MIE  = 3;
  localparam int unsigned MPIE = 7;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  // A write to either half owns the cycle: the untouched half holds as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) q[31:0]  <= wdata;
      if (wr_hi) q[63:32] <= wdata;
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr accesses, 64-bit cycle/instret counters, and
// one-cycle pipeline redirects for illegal-instruction traps and mret.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_1100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csrsel,
  input  logic            csrread,
  input  logic            csrwrite,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      uimm,
  input  logic            illegal_ins,
  input  logic            mret,
  input  logic            retire,
  input  logic [XLEN-1:0] cur_pc,
  input  logic [XLEN-1:0] ins_word,
  output logic [XLEN-1:0] rdata,
  output logic            csr_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  csr_state_t state, state_nxt;

  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, redirect_pc_q;
  logic [63:0]     mcycle, minstret;

  logic            implemented, run, trap, mret_take, wr_en;
  logic [XLEN-1:0] csr_val, src, wdata;
  csr_op_t         op;

  assign implemented = csr_implemented(csr_addr);
  assign csr_illegal = (csrread | csrwrite) &
                       (~implemented | (csrwrite & (csr_addr[11:10] == 2'b11)));

  // Priority trap > mret > write; everything but the cycle counter is frozen in REDIRECT.
  assign run       = (state == RUN);
  assign trap      = run & (illegal_ins | csr_illegal);
  assign mret_take = run & mret & ~trap;
  assign wr_en     = run & csrwrite & ~trap & ~mret_take;

  always_comb begin
    csr_val = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_val[12:11] = 2'b11;
        csr_val[MIE]   = mie;
        csr_val[MPIE]  = mpie;
      end
      CSR_MISA:                    csr_val = MISA_VAL;
      CSR_MTVEC:                   csr_val = mtvec;
      CSR_MSCRATCH:                csr_val = mscratch;
      CSR_MEPC:                    csr_val = mepc;
      CSR_MCAUSE:                  csr_val = mcause;
      CSR_MTVAL:                   csr_val = mtval;
      CSR_MCYCLE, CSR_CYCLE:       csr_val = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     csr_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   csr_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_val = minstret[63:32];
      default:                     csr_val = '0;
    endcase
  end

  assign rdata = (csrread & implemented) ? csr_val : '0;

  always_comb begin
    src   = csrsel[2] ? {{(XLEN-5){1'b0}}, uimm} : rs1_data;
    op    = csr_op_t'(csrsel);
    wdata = csr_val;
    case (op)
      CSR_RW, CSR_RWI: wdata = src;
      CSR_RS, CSR_RSI: wdata = csr_val | src;
      CSR_RC, CSR_RCI: wdata = csr_val & ~src;
      default:         wdata = csr_val;
    endcase
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (wr_en & (csr_addr == CSR_MCYCLE)),
    .wr_hi (wr_en & (csr_addr == CSR_MCYCLEH)),
    .wdata (wdata),
    .q     (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run & retire),
    .wr_lo (wr_en & (csr_addr == CSR_MINSTRET)),
    .wr_hi (wr_en & (csr_addr == CSR_MINSTRETH)),
    .wdata (wdata),
    .q     (minstret)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (trap || mret_take) state_nxt = REDIRECT;
      REDIRECT: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    redirect = 1'b0;
    if (state == REDIRECT) redirect = 1'b1;
  end

  assign redirect_pc = redirect_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie           <= 1'b0;
      mpie          <= 1'b0;
      mtvec         <= '0;
      mscratch      <= '0;
      mepc          <= '0;
      mcause        <= '0;
      mtval         <= '0;
      redirect_pc_q <= '0;
    end else if (trap) begin
      mepc          <= {cur_pc[XLEN-1:2], 2'b00};
      mcause        <= ILLEGAL_INS;
      mtval         <= ins_word;
      mpie          <= mie;
      mie           <= 1'b0;
      redirect_pc_q <= {mtvec[XLEN-1:2], 2'b00};
    end else if (mret_take) begin
      mie           <= mpie;
      mpie          <= 1'b1;
      redirect_pc_q <= mepc;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= wdata[MIE];
          mpie <= wdata[MPIE];
        end
        CSR_MTVEC:    mtvec    <= {wdata[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch <= wdata;
        CSR_MEPC:     mepc     <= {wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause   <= wdata;
        CSR_MTVAL:    mtval    <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed vector table, counter/reset
// sequences, and randomized traffic checked against a register-level model.
module tb_csr_file;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  sel;
    logic        rd, wr;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic        ill, mret, ret;
    logic [31:0] pc, ins;
    logic        chk;
    logic [31:0] e_rdata;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_ill;
  } vec_t;

  logic        clk, rst_n;
  logic [11:0] csr_addr;
  logic [2:0]  csrsel;
  logic        csrread, csrwrite, illegal_ins, mret, retire;
  logic [31:0] rs1_data, cur_pc, ins_word;
  logic [4:0]  uimm;
  logic [31:0] rdata, redirect_pc;
  logic        csr_illegal, redirect;

  int errors = 0;
  int checks = 0;

  csr_file #(.XLEN(32), .MISA_VAL(32'h4000_1100)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csrsel(csrsel),
    .csrread(csrread), .csrwrite(csrwrite), .rs1_data(rs1_data), .uimm(uimm),
    .illegal_ins(illegal_ins), .mret(mret), .retire(retire), .cur_pc(cur_pc),
    .ins_word(ins_word), .rdata(rdata), .csr_illegal(csr_illegal),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural state of the model
  logic        m_mie, m_mpie, m_redir;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
  logic [63:0] m_mcycle, m_minstret;
  logic [11:0] all_addrs [20];
  logic [2:0]  sels [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_impl(input logic [11:0] a);
    for (int i = 0; i < 15; i++) if (all_addrs[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_value(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: return 32'h4000_1100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hB82, 12'hC82: return m_minstret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_bad(input vec_t v);
    return (v.rd || v.wr) && (!m_impl(v.addr) || (v.wr && v.addr[11:10] == 2'b11));
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_redir = 0;
    m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_rpc = 0;
    m_mcycle = 0; m_minstret = 0;
  endtask

  task automatic model_step(input vec_t v);
    logic run, trap, mr, wr;
    logic [31:0] old, src, nv;
    logic [63:0] cyc, ins;
    run  = !m_redir;
    trap = run && (v.ill || m_bad(v));
    mr   = run && v.mret && !trap;
    wr   = run && v.wr && !trap && !mr;
    old  = m_value(v.addr);
    src  = v.sel[2] ? {27'd0, v.uimm} : v.rs1;
    case (v.sel[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    cyc = m_mcycle + 64'd1;
    ins = m_minstret + ((run && v.ret) ? 64'd1 : 64'd0);
    if (wr) begin
      case (v.addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec    = nv & ~32'd3;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'd3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        12'hB00: cyc = {m_mcycle[63:32], nv};
        12'hB80: cyc = {nv, m_mcycle[31:0]};
        12'hB02: ins = {m_minstret[63:32], nv};
        12'hB82: ins = {nv, m_minstret[31:0]};
        default: ;
      endcase
    end
    m_mcycle   = cyc;
    m_minstret = ins;
    if (trap) begin
      m_mepc   = v.pc & ~32'd3;
      m_mcause = 32'd2;
      m_mtval  = v.ins;
      m_mpie   = m_mie;
      m_mie    = 1'b0;
      m_rpc    = m_mtvec & ~32'd3;
    end else if (mr) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
      m_rpc  = m_mepc;
    end
    m_redir = trap || mr;
  endtask

  task automatic apply(input vec_t v);
    csr_addr = v.addr; csrsel = v.sel; csrread = v.rd; csrwrite = v.wr;
    rs1_data = v.rs1; uimm = v.uimm; illegal_ins = v.ill; mret = v.mret;
    retire = v.ret; cur_pc = v.pc; ins_word = v.ins;
  endtask

  function automatic vec_t mk(input logic [11:0] addr, input logic [2:0] sel,
                              input logic rd, input logic wr, input logic [31:0] rs1,
                              input logic [4:0] uimm, input logic ill, input logic mr,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] er, input logic eredir,
                              input logic [31:0] erpc, input logic eill);
    vec_t v;
    v.addr = addr; v.sel = sel; v.rd = rd; v.wr = wr; v.rs1 = rs1; v.uimm = uimm;
    v.ill = ill; v.mret = mr; v.ret = 1'b0; v.pc = pc; v.ins = ins;
    v.chk = 1'b1; v.e_rdata = er; v.e_redir = eredir; v.e_rpc = erpc; v.e_ill = eill;
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = mk(12'h000, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.chk = 1'b0;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    v = idle();
    v.addr = all_addrs[$urandom_range(0, 19)];
    v.sel  = sels[$urandom_range(0, 5)];
    v.rd   = 1'($urandom_range(0, 1));
    v.wr   = 1'($urandom_range(0, 1));
    v.rs1  = $urandom;
    v.uimm = 5'($urandom);
    v.ill  = ($urandom_range(0, 11) == 0);
    v.mret = ($urandom_range(0, 9) == 0);
    v.ret  = 1'($urandom_range(0, 1));
    v.pc   = $urandom;
    v.ins  = $urandom;
    return v;
  endfunction

  // One clock: drive after the falling edge, compare, then advance the model at the rising edge.
  task automatic run_vec(input vec_t v);
    logic [31:0] er;
    @(negedge clk);
    apply(v);
    #1;
    er = (v.rd && m_impl(v.addr)) ? m_value(v.addr) : 32'h0;
    check("mdl_rdata", rdata, er);
    check("mdl_csr_illegal", {31'd0, csr_illegal}, {31'd0, m_bad(v)});
    check("mdl_redirect", {31'd0, redirect}, {31'd0, m_redir});
    check("mdl_redirect_pc", redirect_pc, m_rpc);
    if (v.chk) begin
      check("tbl_rdata", rdata, v.e_rdata);
      check("tbl_csr_illegal", {31'd0, csr_illegal}, {31'd0, v.e_ill});
      check("tbl_redirect", {31'd0, redirect}, {31'd0, v.e_redir});
      check("tbl_redirect_pc", redirect_pc, v.e_rpc);
    end
    @(posedge clk);
    model_step(v);
  endtask

  // Called just after a rising edge: holds reset low for half a cycle mid-period.
  task automatic pulse_reset();
    apply(idle());
    #1 rst_n = 1'b0;
    #1;
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    #4 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_step(idle());
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    all_addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                  12'hC82, 12'h7C0, 12'h344, 12'hB01, 12'hC01, 12'h000};
    sels = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    @(posedge clk);
    pulse_reset();

    // CSR ops, trap, mret, illegal accesses
    tbl.push_back(mk(12'h340, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(12'h340, 3'b001, 1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(12'h340, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'h0, 0));
    tbl.push_back(mk(12'h340, 3'b111, 1, 1, 0, 5'h0F, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'h0, 0));
    tbl.push_back(mk(12'h340, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEE0, 0, 32'h0, 0));
    tbl.push_back(mk(12'h305, 3'b001, 1, 1, 32'h103, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(12'h305, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h0, 0));
    tbl.push_back(mk(12'h300, 3'b110, 1, 1, 0, 5'h08, 0, 0, 0, 0, 32'h1800, 0, 32'h0, 0));
    tbl.push_back(mk(12'h300, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1808, 0, 32'h0, 0));
    tbl.push_back(mk(12'h000, 3'b000, 0, 0, 0, 0, 1, 0, 32'h80, 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(12'h341, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h80, 1, 32'h100, 0));
    tbl.push_back(mk(12'h342, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h2, 0, 32'h100, 0));
    tbl.push_back(mk(12'h343, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h100, 0));
    tbl.push_back(mk(12'h300, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1880, 0, 32'h100, 0));
    tbl.push_back(mk(12'h000, 3'b000, 0, 0, 0, 0, 0, 1, 32'h90, 0, 32'h0, 0, 32'h100, 0));
    tbl.push_back(mk(12'h300, 3'b010, 1, 0, 0, 0, 1, 0, 32'h200, 0, 32'h1888, 1, 32'h80, 0));
    tbl.push_back(mk(12'h300, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1888, 0, 32'h80, 0));
    tbl.push_back(mk(12'h341, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 32'h80, 0));
    tbl.push_back(mk(12'hC00, 3'b001, 0, 1, 32'h123, 0, 0, 0, 32'h300, 0, 32'h0, 0, 32'h80, 1));
    tbl.push_back(mk(12'h342, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h2, 1, 32'h100, 0));
    tbl.push_back(mk(12'h341, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h300, 0, 32'h100, 0));
    tbl.push_back(mk(12'h7C0, 3'b010, 1, 0, 0, 0, 0, 0, 32'h400, 32'hABCD_0001, 32'h0, 0, 32'h100, 1));
    tbl.push_back(mk(12'h341, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h400, 1, 32'h100, 0));
    tbl.push_back(mk(12'h343, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'hABCD_0001, 0, 32'h100, 0));
    foreach (tbl[i]) run_vec(tbl[i]);

    // Counter wrap through the 64-bit boundary
    run_vec(mk(12'hB80, 3'b001, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));
    run_vec(mk(12'hB00, 3'b001, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));
    run_vec(mk(12'hB00, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 32'h100, 0));
    run_vec(mk(12'hB80, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'h100, 0));
    run_vec(mk(12'hB00, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));
    run_vec(mk(12'hB80, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));

    // Retired-instruction count from a cleared counter
    run_vec(mk(12'hB02, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));
    run_vec(mk(12'hB82, 3'b001, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));
    for (int i = 0; i < 4; i++) begin
      v = idle();
      v.ret = (i != 1);
      run_vec(v);
    end
    run_vec(mk(12'hC02, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h3, 0, 32'h100, 0));
    run_vec(mk(12'hC82, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h100, 0));

    for (int i = 0; i < 600; i++) run_vec(rnd());

    // Reset pulse landing inside a REDIRECT cycle
    v = idle();
    v.ill = 1'b1;
    v.pc  = 32'h1234;
    if (m_redir) run_vec(idle());
    run_vec(v);
    #1;
    check("pre_reset_redirect", {31'd0, redirect}, 32'd1);
    pulse_reset();
    run_vec(mk(12'h300, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1800, 0, 32'h0, 0));
    run_vec(mk(12'h305, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    run_vec(mk(12'h340, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    run_vec(mk(12'h341, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    run_vec(mk(12'h342, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    run_vec(mk(12'h343, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    run_vec(mk(12'hB02, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    run_vec(mk(12'hB80, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    v = idle();
    v.addr = 12'hC00;
    v.rd   = 1'b1;
    run_vec(v);
    run_vec(mk(12'h301, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h4000_1100, 0, 32'h0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control/status register file for the Mini-RISC-V core. It is the responder to the decoder's `csrsel`/`csrread`/`csrwrite`/`illegal_ins` outputs. It executes CSRRW/RS/RC and their immediate forms, maintains 64-bit cycle and retired-instruction counters, and sequences illegal-instruction traps and `mret` as one-cycle pipeline redirects. It sits beside the register file in the decode/execute boundary and returns CSR read data to the writeback mux.

## Interface
- `XLEN`, default 32: data width; only 32 is supported.
- `MISA_VAL`, default 32'h4000_1100: read-only `misa` value (RV32IM).
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `csr_addr` input 12: instruction bits [31:20].
- `csrsel` input 3: funct3. 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csrread` / `csrwrite` input 1 each: access strobes, already qualified by stall and rd/rs1==0.
- `rs1_data` input 32: source operand for register forms.
- `uimm` input 5: zero-extended source for immediate forms (`csrsel[2]`=1).
- `illegal_ins` input 1: decoder illegal-instruction flag.
- `mret` input 1: `mret` in execute.
- `retire` input 1: one instruction retired this cycle.
- `cur_pc` input 32: PC of the instruction presenting `illegal_ins`, `mret` or the CSR op.
- `ins_word` input 32: raw instruction, captured into `mtval` on a trap.
- `rdata` output 32: old CSR value.
- `csr_illegal` output 1: access to an unimplemented CSR, or a write to a read-only CSR.
- `redirect` output 1: pipeline must flush and fetch from `redirect_pc`.
- `redirect_pc` output 32: trap vector or `mepc`.

## Operation
- Implemented CSRs:
  - `mstatus` 0x300: MIE bit3, MPIE bit7. MPP[12:11] reads 2'b11. All other bits read 0.
  - `misa` 0x301: read-only.
  - `mtvec` 0x305: direct mode only; bits[1:0] read 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bits[1:0] read 0.
  - `mcause` 0x342.
  - `mtval` 0x343.
  - `mcycle`/`mcycleh` 0xB00/0xB80.
  - `minstret`/`minstreth` 0xB02/0xB82.
  - `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only shadows.
- Source operand `src` = `csrsel[2]` ? {27'b0,`uimm`} : `rs1_data`.
- New value: RW → `src`; RS → old | `src`; RC → old & ~`src`.
- `rdata` is combinational from current state (read-before-write). It outputs 0 when `csrread`=0 or the address is unimplemented.
- `csr_illegal` = (`csrread`|`csrwrite`) & (unimplemented address | (`csrwrite` & address[11:10]==2'b11)). When it is asserted, no CSR changes.
- FSM states:
  - RUN: normal operation.
  - REDIRECT: one cycle long; `redirect`=1.
- RUN → REDIRECT on `illegal_ins` | `csr_illegal` (trap) or on `mret`. REDIRECT → RUN unconditionally.
- In REDIRECT, all of `illegal_ins`, `mret`, `csrwrite` and `retire` are ignored, because those slots are flushed.
- Trap update (at the edge leaving RUN):
  - `mepc`←`cur_pc`, `mcause`←2, `mtval`←`ins_word`.
  - MPIE←MIE, MIE←0.
  - `redirect_pc` latched ← {`mtvec`[31:2],2'b00}.
- Mret update: MIE←MPIE, MPIE←1; `redirect_pc` latched ← `mepc`.
- Priority for simultaneous events: trap > `mret` > CSR write. A trapping instruction writes no CSR other than the trap CSRs.
- Counters:
  - `mcycle` increments every cycle.
  - `minstret` increments on `retire` in RUN.
  - Increments are 64-bit with carry from low into high word; 2^64−1 wraps to 0.
  - A CSR write to either half of a counter in a cycle replaces that half and suppresses the increment of the whole counter for that cycle.

## Timing
- Reset values:
  - `mstatus`=0 (MPP reads 11), `mtvec`=0, `mscratch`=0, `mepc`=0, `mcause`=0, `mtval`=0.
  - Counters=0.
  - FSM=RUN, `redirect`=0, `redirect_pc`=0.
  - `rdata` = 0.
- Reset asserted mid-REDIRECT returns to RUN immediately. No partial update is applied.
- CSR write latency: the value is visible on `rdata` in the cycle after the write edge.
- Trap/mret latency: `redirect` rises 1 cycle after the `illegal_ins`/`mret` cycle and lasts exactly 1 cycle.
- A counter read in cycle N returns the pre-increment value of cycle N.

## Structure
- `csr_pkg` holds:
  - CSR address localparams.
  - Enum `csr_op_t` for the `csrsel` encodings.
  - Enum `csr_state_t` {RUN, REDIRECT}.
  - `mcause` code constants (ILLEGAL_INS=2).
  - Bit-position constants MIE=3, MPIE=7.
- Sub-module `csr_counter64` (ports: `clk`, `rst_n`, `inc`, `wr_lo`, `wr_hi`, `wdata`, `q[63:0]`). It is instantiated for `mcycle` and for `minstret`.

## Test plan
- CSRRW: `mscratch`, `rs1_data`=32'hDEAD_BEEF. `rdata` shows the old value 0; the next cycle, a read returns DEADBEEF. Then CSRRCI with `uimm`=5'h0F reads DEADBEEF and leaves DEADBEE0.
- Illegal trap: `mtvec`=32'h0000_0103, MIE=1, `cur_pc`=32'h80, `illegal_ins`=1.
  - Next cycle: `redirect`=1 and `redirect_pc`=32'h100.
  - `mepc`=32'h80, `mcause`=2, `mtval`=`ins_word`, MIE=0, MPIE=1.
  - `redirect`=0 the cycle after.
- Mret after the trap: `redirect_pc`=32'h80, MIE=1, MPIE=1. An `illegal_ins` asserted during REDIRECT causes no second trap.
- Counter wrap: write `mcycleh`=FFFFFFFF, then `mcycle`=FFFFFFFE.
  - 2 cycles later the pair reads 0000_0000_0000_0000.
  - With `retire` pulsed 3 times, `instret`=3.
- Read-only/unimplemented: `csrwrite` to 0xC00 → `csr_illegal`=1, trap taken, counter unaltered. `csrread` of 0x7C0 → `rdata`=0 and trap taken.
- Async reset during REDIRECT with `rst_n` low for half a cycle: `redirect` drops to 0 at once, and all CSRs read their reset values.
